// File: rtl/hs_arb_pkg.sv
// hs_arb_pkg: shared types and helpers for the round-robin packet arbiter.
// Holds the arbiter state enum, the round-robin pick and a clog2 helper.
package hs_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // First requester at or after (ptr+1) mod n with req set; 0 if none.
  function automatic int rr_pick(
    input logic [31:0] req,
    input int          ptr,
    input int          n
  );
    int   idx;
    logic hit;
    rr_pick = 0;
    hit     = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (!hit && req[idx[4:0]]) begin
          rr_pick = idx;
          hit     = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/hs_skid_buf.sv
// hs_skid_buf: 2-entry registered FIFO used as the arbiter output stage.
// in_ready_o depends only on occupancy, so there is no ready feed-through.
module hs_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic [W-1:0] m0_q, m1_q;
  logic         wp_q, rp_q;
  logic [1:0]   cnt_q;
  logic         push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_data_o  = rp_q ? m1_q : m0_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Storage, pointers and occupancy; empty after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m0_q  <= '0;
      m1_q  <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        if (wp_q) m1_q <= in_data_i;
        else      m0_q <= in_data_i;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/hs_rr_pkt_arbiter.sv
// hs_rr_pkt_arbiter: N:1 valid/ready round-robin arbiter with packet lock.
// Define HS_RR_PKT_ARB_OUT_REG_EN to add a registered 2-entry output stage.
module hs_rr_pkt_arbiter
  import hs_arb_pkg::*;
#(
  parameter int REQ_NUM   = 8,
  parameter int DATA_WD   = 32,
  parameter int USE_LAST  = 1,
  parameter int MAX_BURST = 16,
  parameter int ID_WD     = $clog2(REQ_NUM)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [REQ_NUM-1:0]         valid_in,
  input  logic [REQ_NUM*DATA_WD-1:0] data_in,
  input  logic [REQ_NUM-1:0]         last_in,
  output logic [REQ_NUM-1:0]         ready_in,
  output logic                       valid_out,
  output logic [DATA_WD-1:0]         data_out,
  output logic                       last_out,
  output logic [ID_WD-1:0]           id_out,
  input  logic                       ready_out,
  output logic                       busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e       state_q, state_d;
  logic [ID_WD-1:0] ptr_q, ptr_d;
  logic [ID_WD-1:0] gid_q, gid_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic               is_lock;
  logic               lane_vld;
  logic [DATA_WD-1:0] lane_data;
  logic               cnt_hit;
  logic               lane_last;
  logic               in_vld;
  logic               rdy;
  logic               fire;

  assign is_lock   = (state_q == LOCK);
  assign lane_vld  = valid_in[gid_q];
  assign lane_data = data_in[int'(gid_q)*DATA_WD +: DATA_WD];
  assign cnt_hit   = (cnt_q == CW'(MAX_BURST - 1));
  assign lane_last = (USE_LAST != 0) ? last_in[gid_q] : cnt_hit;
  assign in_vld    = is_lock & lane_vld;
  assign fire      = in_vld & rdy;
  assign busy      = is_lock;

`ifdef HS_RR_PKT_ARB_OUT_REG_EN
  logic buf_rdy;

  hs_skid_buf #(
    .W(DATA_WD + 1 + ID_WD)
  ) u_skid (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid_i (in_vld),
    .in_ready_o (buf_rdy),
    .in_data_i  ({lane_last, lane_data, gid_q}),
    .out_valid_o(valid_out),
    .out_ready_i(ready_out),
    .out_data_o ({last_out, data_out, id_out})
  );

  assign rdy = buf_rdy;
`else
  assign rdy       = ready_out;
  assign valid_out = in_vld;
  assign data_out  = is_lock ? lane_data : '0;
  assign last_out  = is_lock & lane_last;
  assign id_out    = gid_q;
`endif

  // Only the locked lane ever sees ready.
  always_comb begin
    ready_in        = '0;
    ready_in[gid_q] = is_lock & rdy;
  end

  // Grant selection in IDLE, beat counting and release in LOCK.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|valid_in) begin
          gid_d   = ID_WD'(rr_pick(32'(valid_in), int'(ptr_q), REQ_NUM));
          ptr_d   = gid_d;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (fire) begin
          if (lane_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= ID_WD'(REQ_NUM - 1);
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hs_rr_pkt_arbiter.sv
// tb_hs_rr_pkt_arbiter: vector table plus scoreboarded packet sequences.
// u0 uses last-based release, u1 uses a 4-beat burst cap.
module tb_hs_rr_pkt_arbiter;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [N-1:0]    v0, l0, ri0;
  logic [N*32-1:0] d0;
  logic            ro0, vo0, lo0, busy0;
  logic [31:0]     do0;
  logic [2:0]      id0;

  logic [N-1:0]    v1, l1, ri1;
  logic [N*32-1:0] d1;
  logic            ro1, vo1, lo1, busy1;
  logic [31:0]     do1;
  logic [2:0]      id1;

  hs_rr_pkt_arbiter #(
    .REQ_NUM(N), .DATA_WD(32), .USE_LAST(1), .MAX_BURST(16)
  ) u0 (
    .clk(clk), .rstn(rstn), .valid_in(v0), .data_in(d0),
    .last_in(l0), .ready_in(ri0), .valid_out(vo0), .data_out(do0),
    .last_out(lo0), .id_out(id0), .ready_out(ro0), .busy(busy0)
  );

  hs_rr_pkt_arbiter #(
    .REQ_NUM(N), .DATA_WD(32), .USE_LAST(0), .MAX_BURST(4)
  ) u1 (
    .clk(clk), .rstn(rstn), .valid_in(v1), .data_in(d1),
    .last_in(l1), .ready_in(ri1), .valid_out(vo1), .data_out(do1),
    .last_out(lo1), .id_out(id1), .ready_out(ro1), .busy(busy1)
  );

  int nvec = 0;
  int nerr = 0;
  int pops = 0;

  typedef struct packed {
    logic [2:0]  id;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [32:0]  src[N][$];
  logic [N-1:0] mask;
  logic [N-1:0] fired;

  typedef struct packed {
    logic        dut;
    logic        rst;
    logic [7:0]  v;
    logic [7:0]  l;
    logic        ro;
    logic        evo;
    logic [7:0]  eri;
    logic [2:0]  eid;
    logic        ebusy;
    logic        elast;
    logic [31:0] edata;
  } vec_t;

  vec_t tv[18];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0 && !mask[i]) begin
        v0[i]          = 1'b1;
        l0[i]          = src[i][0][32];
        d0[i*32 +: 32] = src[i][0][31:0];
      end else begin
        v0[i]          = 1'b0;
        l0[i]          = 1'b0;
        d0[i*32 +: 32] = '0;
      end
    end
  endtask

  task automatic step();
    beat_t e;
    @(negedge clk);
    fired = v0 & ri0;
    if (vo0 && ro0) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL sb_extra got id=%0d data=%h exp=none", id0, do0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_id", 32'(id0), 32'(e.id));
        chk("sb_data", do0, e.data);
        chk("sb_last", 32'(lo0), 32'(e.last));
        pops++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (fired[i] && src[i].size() > 0) void'(src[i].pop_front());
    drive();
  endtask

  task automatic add_pkt(input int lane, input int n, input logic [31:0] base);
    beat_t e;
    for (int b = 0; b < n; b++) begin
      src[lane].push_back({(b == n - 1), base + 32'(b)});
      e.id   = 3'(lane);
      e.last = (b == n - 1);
      e.data = base + 32'(b);
      exp_q.push_back(e);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    mask  = '0;
    fired = '0;
    pops  = 0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    flush();
    v0 = '0; l0 = '0; d0 = '0; ro0 = 1'b0;
    v1 = '0; l1 = '0; d1 = '0; ro1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic drain(input string nm, input int budget);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      step();
      c++;
    end
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s_timeout got=%0d beats left exp=0", nm, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic wait_pops(input string nm, input int n);
    int c;
    c = 0;
    while (pops < n && c < 40) begin
      step();
      c++;
    end
    nvec++;
    if (pops < n) begin
      nerr++;
      $display("FAIL %s_wait got=%0d pops exp=%0d", nm, pops, n);
    end
  endtask

  initial begin
    logic [7:0]  s_eri;
    logic [31:0] s_dat;
    logic [2:0]  s_id;
    logic        s_vo, s_busy, s_last;

    tv[0]  = '{0, 1, 8'h05, 8'h05, 1, 0, 8'h00, 3'd0, 0, 0, 32'h0};
    tv[1]  = '{0, 0, 8'h05, 8'h05, 1, 1, 8'h01, 3'd0, 1, 1, 32'hD0000000};
    tv[2]  = '{0, 0, 8'h05, 8'h05, 1, 0, 8'h00, 3'd0, 0, 0, 32'h0};
    tv[3]  = '{0, 0, 8'h05, 8'h05, 1, 1, 8'h04, 3'd2, 1, 1, 32'hD0000002};
    tv[4]  = '{0, 0, 8'h05, 8'h05, 1, 0, 8'h00, 3'd2, 0, 0, 32'h0};
    tv[5]  = '{0, 0, 8'h05, 8'h05, 1, 1, 8'h01, 3'd0, 1, 1, 32'hD0000000};
    tv[6]  = '{0, 0, 8'h05, 8'h05, 1, 0, 8'h00, 3'd0, 0, 0, 32'h0};
    tv[7]  = '{0, 0, 8'h05, 8'h05, 1, 1, 8'h04, 3'd2, 1, 1, 32'hD0000002};
    tv[8]  = '{1, 1, 8'h20, 8'h00, 1, 0, 8'h00, 3'd0, 0, 0, 32'h0};
    tv[9]  = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[10] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[11] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[12] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 1, 32'hD0000005};
    tv[13] = '{1, 0, 8'h20, 8'h00, 1, 0, 8'h00, 3'd5, 0, 0, 32'h0};
    tv[14] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[15] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[16] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 0, 32'hD0000005};
    tv[17] = '{1, 0, 8'h20, 8'h00, 1, 1, 8'h20, 3'd5, 1, 1, 32'hD0000005};

    rstn = 1'b0;
    flush();
    v0 = '0; l0 = '0; d0 = '0; ro0 = 1'b1;
    v1 = '0; l1 = '0; d1 = '0; ro1 = 1'b1;
    #1;
    chk("rst_valid", 32'(vo0), 0);
    chk("rst_ready", 32'(ri0), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_id", 32'(id0), 0);
    chk("rst_data", do0, 0);
    chk("rst_last", 32'(lo0), 0);
    chk("rst_busy1", 32'(busy1), 0);

    for (int r = 0; r < 18; r++) begin
      if (tv[r].rst) do_reset();
      for (int i = 0; i < N; i++) begin
        d0[i*32 +: 32] = 32'hD0000000 | 32'(i);
        d1[i*32 +: 32] = 32'hD0000000 | 32'(i);
      end
      if (tv[r].dut) begin
        v1 = tv[r].v; l1 = tv[r].l; ro1 = tv[r].ro;
      end else begin
        v0 = tv[r].v; l0 = tv[r].l; ro0 = tv[r].ro;
      end
      @(negedge clk);
      s_vo   = tv[r].dut ? vo1   : vo0;
      s_eri  = tv[r].dut ? ri1   : ri0;
      s_id   = tv[r].dut ? id1   : id0;
      s_busy = tv[r].dut ? busy1 : busy0;
      s_last = tv[r].dut ? lo1   : lo0;
      s_dat  = tv[r].dut ? do1   : do0;
      chk($sformatf("r%0d_valid", r), 32'(s_vo), 32'(tv[r].evo));
      chk($sformatf("r%0d_ready", r), 32'(s_eri), 32'(tv[r].eri));
      chk($sformatf("r%0d_id", r), 32'(s_id), 32'(tv[r].eid));
      chk($sformatf("r%0d_busy", r), 32'(s_busy), 32'(tv[r].ebusy));
      chk($sformatf("r%0d_last", r), 32'(s_last), 32'(tv[r].elast));
      chk($sformatf("r%0d_data", r), s_dat, tv[r].edata);
      @(posedge clk);
      #1;
    end

    // two simultaneous 4-beat packets: lane 1 whole, then lane 3
    do_reset();
    ro0 = 1'b1;
    add_pkt(1, 4, 32'h100);
    add_pkt(3, 4, 32'h300);
    drive();
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      step();
      if (busy0 && id0 == 3'd1) chk("t2_rdy3", 32'(ri0[3]), 0);
    end
    drain("t2", 5);

    // downstream stall mid-packet
    do_reset();
    ro0 = 1'b1;
    add_pkt(4, 4, 32'h400);
    drive();
    wait_pops("t4", 2);
    ro0 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_valid", 32'(vo0), 1);
      chk("t4_data", do0, 32'h402);
      chk("t4_busy", 32'(busy0), 1);
      chk("t4_id", 32'(id0), 4);
      step();
    end
    ro0 = 1'b1;
    drain("t4", 20);

    // granted lane pauses; lane 6 waits for the packet to finish
    do_reset();
    ro0 = 1'b1;
    add_pkt(2, 4, 32'h200);
    add_pkt(6, 2, 32'h600);
    drive();
    wait_pops("t5", 2);
    mask[2] = 1'b1;
    drive();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_valid", 32'(vo0), 0);
      chk("t5_rdy6", 32'(ri0[6]), 0);
      chk("t5_busy", 32'(busy0), 1);
      chk("t5_id", 32'(id0), 2);
      step();
    end
    mask[2] = 1'b0;
    drive();
    drain("t5", 20);

    // reset during beat 2 abandons the packet
    do_reset();
    ro0 = 1'b1;
    add_pkt(3, 4, 32'h300);
    drive();
    wait_pops("t6", 1);
    rstn = 1'b0;
    #1;
    chk("t6_valid", 32'(vo0), 0);
    chk("t6_ready", 32'(ri0), 0);
    chk("t6_busy", 32'(busy0), 0);
    chk("t6_id", 32'(id0), 0);
    chk("t6_data", do0, 0);
    chk("t6_last", 32'(lo0), 0);
    flush();
    drive();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    add_pkt(0, 1, 32'hA0);
    add_pkt(3, 1, 32'hA3);
    drive();
    drain("t6", 10);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
